// File: rtl/vector_list_writer.sv
// rtl/vector_list_writer.sv - packs draw commands into a ping-pong vector-list RAM, pads, swaps on frame_drawn
// Optional VECTOR_WRITER_STATS_EN adds dropped_cnt (overflow-dropped command counter).
module vector_list_writer #(
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18,
  parameter int FRAME_MIN    = 0,
  parameter int FRAME_MAX    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OUT_WIDTH-1:0]    cmd_x,
  input  logic [OUT_WIDTH-1:0]    cmd_y,
  input  logic                    cmd_line,
  input  logic                    cmd_pos,
  input  logic                    cmd_last,
  input  logic                    frame_drawn,
  output logic                    wr_en,
  output logic                    wr_bank,
  output logic [ADDRESSWIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0]    wr_data,
  output logic                    rd_bank,
  output logic                    swapped,
  output logic                    overflow
`ifdef VECTOR_WRITER_STATS_EN
  ,
  output logic [7:0]              dropped_cnt
`endif
);

  typedef enum logic [1:0] {S_WRITE, S_PAD, S_WAIT_SWAP} state_t;

  // One extra pointer bit so that "past FRAME_MAX" is representable even when FRAME_MAX is the top address.
  localparam logic [ADDRESSWIDTH:0] PTR_MIN = (ADDRESSWIDTH+1)'(FRAME_MIN);
  localparam logic [ADDRESSWIDTH:0] PTR_MAX = (ADDRESSWIDTH+1)'(FRAME_MAX);

  state_t                    state_q, state_d;
  logic [ADDRESSWIDTH:0]     ptr_q, ptr_d, ptr_inc;
  logic                      wr_en_q, wr_en_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [ADDRESSWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]      wr_data_q, wr_data_d;
  logic                      swapped_q, swapped_d;
  logic                      overflow_q, overflow_d;
  logic [2*OUT_WIDTH-1:0]    last_xy_q, last_xy_d;
  logic                      accept, in_range, drop, do_swap;

  assign ptr_inc  = ptr_q + (ADDRESSWIDTH+1)'(1);
  assign in_range = (ptr_q <= PTR_MAX);
  assign accept   = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    swapped_d  = 1'b0;
    overflow_d = overflow_q;
    last_xy_d  = last_xy_q;
    drop       = 1'b0;
    do_swap    = 1'b0;
    cmd_ready  = (state_q == S_WRITE);

    case (state_q)
      S_WRITE: begin
        if (accept) begin
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[ADDRESSWIDTH-1:0];
            wr_data_d = DATAWIDTH'({cmd_y, cmd_x, cmd_line, cmd_pos});
            ptr_d     = ptr_inc;
            last_xy_d = {cmd_y, cmd_x};
          end else begin
            overflow_d = 1'b1;
            drop       = 1'b1;
          end
          if (cmd_last) begin
            state_d = (ptr_d <= PTR_MAX) ? S_PAD : S_WAIT_SWAP;
          end
        end
      end
      S_PAD: begin
        // Pad word repositions to the last point without drawing.
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q[ADDRESSWIDTH-1:0];
        wr_data_d = DATAWIDTH'({last_xy_q, 1'b0, 1'b1});
        ptr_d     = ptr_inc;
        if (ptr_q >= PTR_MAX) begin
          state_d = S_WAIT_SWAP;
        end
      end
      S_WAIT_SWAP: begin
        if (frame_drawn) begin
          do_swap    = 1'b1;
          rd_bank_d  = wr_bank_q;
          wr_bank_d  = ~wr_bank_q;
          ptr_d      = PTR_MIN;
          overflow_d = 1'b0;
          swapped_d  = 1'b1;
          state_d    = S_WRITE;
        end
      end
      default: state_d = S_WRITE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WRITE;
      ptr_q      <= PTR_MIN;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b1;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= PTR_MIN[ADDRESSWIDTH-1:0];
      wr_data_q  <= '0;
      swapped_q  <= 1'b0;
      overflow_q <= 1'b0;
      last_xy_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      swapped_q  <= swapped_d;
      overflow_q <= overflow_d;
      last_xy_q  <= last_xy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign swapped  = swapped_q;
  assign overflow = overflow_q;

`ifdef VECTOR_WRITER_STATS_EN
  logic [7:0] dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_q <= 8'd0;
    end else if (do_swap) begin
      dropped_q <= 8'd0;
    end else if (drop && (dropped_q != 8'hFF)) begin
      dropped_q <= dropped_q + 8'd1;
    end
  end

  assign dropped_cnt = dropped_q;
`else
  logic unused_stats;
  assign unused_stats = drop ^ do_swap;
`endif

endmodule
